eight_bit_kogge_stone_adder: RTL and testbench

- 8-bit two's-complement/unsigned adder with carry-in.
- Carry computation uses a 3-level Kogge-Stone parallel-prefix network (log2(8) levels).
- Outputs are the sum, the carry-out and a signed-overflow flag, all registered.
- Used as the narrow integer-add primitive inside the floating-point ALU datapath (e.g. exponent add/subtract).

---
 rtl/eight_bit_kogge_stone_adder_pkg.sv | 5 +
 rtl/eight_bit_kogge_stone_adder_if.sv | 14 +
 rtl/eight_bit_kogge_stone_adder_black_cell.sv | 12 +
 rtl/eight_bit_kogge_stone_adder.sv | 72 +++++++
 tb/tb_eight_bit_kogge_stone_adder.sv | 106 ++++++++++
 5 files changed

// File: rtl/eight_bit_kogge_stone_adder_pkg.sv
// Shared constants for the narrow integer-add blocks of the FP ALU datapath.
package eight_bit_kogge_stone_adder_pkg;
  localparam int ADDER_WIDTH   = 8;
  localparam int PREFIX_LEVELS = 3;
endpackage

// File: rtl/eight_bit_kogge_stone_adder_if.sv
// Operand/result bundle for the 8-bit Kogge-Stone adder.
interface eight_bit_kogge_stone_adder_if;
  import eight_bit_kogge_stone_adder_pkg::*;

  logic [ADDER_WIDTH-1:0] A;
  logic [ADDER_WIDTH-1:0] B;
  logic                   Cin;
  logic [ADDER_WIDTH-1:0] S;
  logic                   Cout;
  logic                   overflowFlag;

  modport master (output A, B, Cin, input S, Cout, overflowFlag);
  modport slave  (input A, B, Cin, output S, Cout, overflowFlag);
endinterface

// File: rtl/eight_bit_kogge_stone_adder_black_cell.sv
// Prefix combine node: merges a higher (G,P) span with the adjacent lower span.
module kogge_stone_black_cell (
  input  logic G_hi,
  input  logic P_hi,
  input  logic G_lo,
  input  logic P_lo,
  output logic G,
  output logic P
);
  assign G = G_hi | (P_hi & G_lo);
  assign P = P_hi & P_lo;
endmodule

// File: rtl/eight_bit_kogge_stone_adder.sv
// 8-bit adder with carry-in, 3-level Kogge-Stone carry network, registered
// sum/carry-out/overflow; 1-cycle latency, no handshake, sync active-high reset.
module eight_bit_kogge_stone_adder
  import eight_bit_kogge_stone_adder_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  eight_bit_kogge_stone_adder_if.slave add_if
);

  logic [ADDER_WIDTH-1:0]                     g;
  logic [ADDER_WIDTH-1:0]                     p;
  logic [PREFIX_LEVELS:0][ADDER_WIDTH-1:0]    gen;
  logic [PREFIX_LEVELS:0][ADDER_WIDTH-1:0]    prop;
  logic [ADDER_WIDTH:0]                       c;
  logic                                       unused_prop;

  logic [ADDER_WIDTH-1:0] s_d, s_q;
  logic                   cout_d, cout_q;
  logic                   ovf_d, ovf_q;

  assign g = add_if.A & add_if.B;
  assign p = add_if.A ^ add_if.B;

  // Carry-in folded into bit 0 so every group generate already includes it.
  assign gen[0]  = {g[ADDER_WIDTH-1:1], g[0] | (p[0] & add_if.Cin)};
  assign prop[0] = {p[ADDER_WIDTH-1:1], 1'b0};

  for (genvar l = 0; l < PREFIX_LEVELS; l++) begin : g_level
    localparam int SPAN = 1 << l;
    for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
        kogge_stone_black_cell u_cell (
          .G_hi (gen[l][i]),
          .P_hi (prop[l][i]),
          .G_lo (gen[l][i-SPAN]),
          .P_lo (prop[l][i-SPAN]),
          .G    (gen[l+1][i]),
          .P    (prop[l+1][i])
        );
      end else begin : g_pass
        assign gen[l+1][i]  = gen[l][i];
        assign prop[l+1][i] = prop[l][i];
      end
    end
  end

  // Final-level propagate has no consumer.
  assign unused_prop = ^prop[PREFIX_LEVELS];

  assign c      = {gen[PREFIX_LEVELS], add_if.Cin};
  assign s_d    = p ^ c[ADDER_WIDTH-1:0];
  assign cout_d = c[ADDER_WIDTH];
  assign ovf_d  = c[ADDER_WIDTH] ^ c[ADDER_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign add_if.S            = s_q;
  assign add_if.Cout         = cout_q;
  assign add_if.overflowFlag = ovf_q;

endmodule

// File: tb/tb_eight_bit_kogge_stone_adder.sv
// Bench for the 8-bit Kogge-Stone adder against an arithmetic reference model.
module tb_eight_bit_kogge_stone_adder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  eight_bit_kogge_stone_adder_if add_if ();

  eight_bit_kogge_stone_adder dut (
    .clk    (clk),
    .rst    (rst),
    .add_if (add_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Applies one operand set for one edge, then compares against plain arithmetic.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic r);
    logic [8:0] full;
    logic [7:0] exp_s;
    logic       exp_c;
    logic       exp_v;
    add_if.A   = a;
    add_if.B   = b;
    add_if.Cin = cin;
    rst        = r;
    @(posedge clk);
    #1;
    full  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    exp_s = r ? 8'h00 : full[7:0];
    exp_c = r ? 1'b0  : full[8];
    exp_v = r ? 1'b0  : ((a[7] == b[7]) && (full[7] != a[7]));
    check({tag, ".S"},    add_if.S,                    exp_s);
    check({tag, ".Cout"}, {7'd0, add_if.Cout},         {7'd0, exp_c});
    check({tag, ".ovf"},  {7'd0, add_if.overflowFlag}, {7'd0, exp_v});
  endtask

  task automatic step_fixed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic r, input logic [7:0] es,
                            input logic ec, input logic ev);
    add_if.A   = a;
    add_if.B   = b;
    add_if.Cin = cin;
    rst        = r;
    @(posedge clk);
    #1;
    check({tag, ".S"},    add_if.S,                    es);
    check({tag, ".Cout"}, {7'd0, add_if.Cout},         {7'd0, ec});
    check({tag, ".ovf"},  {7'd0, add_if.overflowFlag}, {7'd0, ev});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst        = 1'b1;
    add_if.A   = 8'h5A;
    add_if.B   = 8'hC3;
    add_if.Cin = 1'b1;

    step_fixed("rst0",     8'h5A, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step_fixed("rst1",     8'h5A, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step_fixed("zero",     8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step_fixed("zero_cin", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    step_fixed("96CA_c0",  8'h96, 8'hCA, 1'b0, 1'b0, 8'h60, 1'b1, 1'b1);
    step_fixed("96CA_c1",  8'h96, 8'hCA, 1'b1, 1'b0, 8'h61, 1'b1, 1'b1);
    step_fixed("279B_c0",  8'h27, 8'h9B, 1'b0, 1'b0, 8'hC2, 1'b0, 1'b0);
    step_fixed("279B_c1",  8'h27, 8'h9B, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
    step_fixed("ripple",   8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step_fixed("pos_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    step_fixed("mid_rst",  8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step_fixed("post_rst", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      step("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end

    // Every (A, B) pair, with the carry-in chosen at random per pair.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        step("sweep", 8'(a), 8'(b), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    // Sparse resets inside a random stream.
    for (int k = 0; k < 200; k++) begin
      step("rand_rst", 8'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
